// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline: bypass selects, load-use stall,
// branch squash and memory-busy freeze. Define HAZARD_STATS_EN to add per-state cycle counters.
module pipeline_hazard_ctrl #(
    parameter logic [5:0] NOP_OP        = 6'b100001,
    parameter int         SQUASH_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ir_fd,
    input  logic [31:0] ir_dx,
    input  logic [31:0] ir_xm,
    input  logic [31:0] ir_mw,
    input  logic        rwe_dx,
    input  logic        rwe_xm,
    input  logic        rwe_mw,
    input  logic        rdst_dx,
    input  logic        rdst_xm,
    input  logic        rdst_mw,
    input  logic        rwd_dx,
    input  logic        rwd_xm,
    input  logic        dmwe_xm,
    input  logic        do_branch,
    input  logic        i_busy,
    input  logic        d_busy,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic        wm_bypass,
    output logic        hold_f,
    output logic        bubble_dx,
    output logic        flush_fd,
    output logic        freeze,
    output logic [1:0]  state
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] load_stall_cnt,
    output logic [31:0] squash_cnt,
    output logic [31:0] mem_wait_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_LOAD_STALL = 2'b01,
        ST_SQUASH     = 2'b10,
        ST_MEM_WAIT   = 2'b11
    } state_t;

    localparam logic [1:0] SQ_LOAD = 2'(SQUASH_CYCLES - 1);

    state_t     state_reg, state_next;
    logic [1:0] sq_cnt_reg, sq_cnt_next;

    // Destination register per stage; r0 is never a valid producer.
    logic [4:0] dest_dx, dest_xm, dest_mw;
    logic       valid_dx, valid_xm, valid_mw, mx_ok;

    assign dest_dx  = rdst_dx ? ir_dx[15:11] : ir_dx[20:16];
    assign dest_xm  = rdst_xm ? ir_xm[15:11] : ir_xm[20:16];
    assign dest_mw  = rdst_mw ? ir_mw[15:11] : ir_mw[20:16];
    assign valid_dx = rwe_dx && (dest_dx != 5'd0);
    assign valid_xm = rwe_xm && (dest_xm != 5'd0);
    assign valid_mw = rwe_mw && (dest_mw != 5'd0);
    assign mx_ok    = valid_xm && !rwd_xm;

    logic [4:0] x_src   [2];
    logic [1:0] fwd_sel [2];

    assign x_src[0] = ir_dx[25:21];
    assign x_src[1] = ir_dx[20:16];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_sel[gi] = (mx_ok && (dest_xm == x_src[gi]))    ? 2'b01 :
                                 (valid_mw && (dest_mw == x_src[gi])) ? 2'b10 : 2'b00;
        end
    endgenerate

    assign fwd_a_sel = fwd_sel[0];
    assign fwd_b_sel = fwd_sel[1];
    assign wm_bypass = dmwe_xm && valid_mw && (dest_mw == ir_xm[20:16]);

    // Source usage of the instruction in F/D; an injected bubble reads nothing.
    logic [5:0] fd_op;
    logic [4:0] fd_rs, fd_rt;
    logic       fd_bubble, fd_reads_rs, fd_reads_rt, fd_is_store, load_use;

    assign fd_op       = ir_fd[31:26];
    assign fd_rs       = ir_fd[25:21];
    assign fd_rt       = ir_fd[20:16];
    assign fd_bubble   = (fd_op == NOP_OP);
    assign fd_is_store = (fd_op == 6'h2B);
    assign fd_reads_rt = !fd_bubble && ((fd_op == 6'h00) || (fd_op == 6'h04) ||
                                        (fd_op == 6'h05) || fd_is_store);
    assign fd_reads_rs = !fd_bubble && (fd_op != 6'h02) && (fd_op != 6'h03);

    // A store depending only through rt proceeds; the WM bypass supplies its data.
    assign load_use = rwd_dx && valid_dx &&
                      ((fd_reads_rs && (dest_dx == fd_rs)) ||
                       (fd_reads_rt && !fd_is_store && (dest_dx == fd_rt)));

    logic mem_busy;
    assign mem_busy = i_busy || d_busy;

    always_comb begin
        state_next  = state_reg;
        sq_cnt_next = sq_cnt_reg;
        hold_f      = 1'b0;
        bubble_dx   = 1'b0;
        flush_fd    = 1'b0;
        freeze      = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (mem_busy) begin
                    freeze     = 1'b1;
                    state_next = ST_MEM_WAIT;
                end else if (do_branch) begin
                    flush_fd    = 1'b1;
                    bubble_dx   = 1'b1;
                    sq_cnt_next = SQ_LOAD;
                    state_next  = (SQ_LOAD != 2'd0) ? ST_SQUASH : ST_RUN;
                end else if (load_use) begin
                    hold_f     = 1'b1;
                    bubble_dx  = 1'b1;
                    state_next = ST_LOAD_STALL;
                end
            end
            ST_LOAD_STALL: begin
                state_next = ST_RUN;
            end
            ST_SQUASH: begin
                if (mem_busy) begin
                    freeze     = 1'b1;
                    state_next = ST_MEM_WAIT;
                end else begin
                    flush_fd    = 1'b1;
                    bubble_dx   = 1'b1;
                    sq_cnt_next = (sq_cnt_reg == 2'd0) ? 2'd0 : sq_cnt_reg - 2'd1;
                    state_next  = (sq_cnt_reg <= 2'd1) ? ST_RUN : ST_SQUASH;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_busy) begin
                    freeze = 1'b1;
                end else begin
                    state_next = (sq_cnt_reg != 2'd0) ? ST_SQUASH : ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
        if (reset) begin
            hold_f    = 1'b0;
            bubble_dx = 1'b0;
            flush_fd  = 1'b0;
            freeze    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= ST_RUN;
            sq_cnt_reg <= 2'd0;
        end else begin
            state_reg  <= state_next;
            sq_cnt_reg <= sq_cnt_next;
        end
    end

    assign state = state_reg;

`ifdef HAZARD_STATS_EN
    // Index 0/1/2 track LOAD_STALL/SQUASH/MEM_WAIT, i.e. state encodings 1/2/3.
    logic [31:0] stat_cnt_reg [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_stat
            always_ff @(posedge clock) begin
                if (reset) begin
                    stat_cnt_reg[gi] <= 32'd0;
                end else if ((state_reg == state_t'(2'(gi + 1))) && (stat_cnt_reg[gi] != 32'hFFFF_FFFF)) begin
                    stat_cnt_reg[gi] <= stat_cnt_reg[gi] + 32'd1;
                end
            end
        end
    endgenerate

    assign load_stall_cnt = stat_cnt_reg[0];
    assign squash_cnt     = stat_cnt_reg[1];
    assign mem_wait_cnt   = stat_cnt_reg[2];
`endif

    logic unused_bits;
    assign unused_bits = ^{ir_fd[15:0], ir_dx[31:26], ir_dx[10:0],
                           ir_xm[31:21], ir_xm[10:0], ir_mw[31:21], ir_mw[10:0]};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam int         SQ  = 2;
    localparam logic [5:0] NOP = 6'b100001;
    localparam logic [5:0] OPS [8] = '{6'h00, 6'h04, 6'h05, 6'h2B, 6'h23, 6'h08, 6'h02, 6'h03};

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] ir_fd, ir_dx, ir_xm, ir_mw;
    logic        rwe_dx, rwe_xm, rwe_mw, rdst_dx, rdst_xm, rdst_mw;
    logic        rwd_dx, rwd_xm, dmwe_xm, do_branch, i_busy, d_busy;
    logic [1:0]  fwd_a_sel, fwd_b_sel, state;
    logic        wm_bypass, hold_f, bubble_dx, flush_fd, freeze;
`ifdef HAZARD_STATS_EN
    logic [31:0] load_stall_cnt, squash_cnt, mem_wait_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(.NOP_OP(NOP), .SQUASH_CYCLES(SQ)) dut (
        .clock(clock), .reset(reset),
        .ir_fd(ir_fd), .ir_dx(ir_dx), .ir_xm(ir_xm), .ir_mw(ir_mw),
        .rwe_dx(rwe_dx), .rwe_xm(rwe_xm), .rwe_mw(rwe_mw),
        .rdst_dx(rdst_dx), .rdst_xm(rdst_xm), .rdst_mw(rdst_mw),
        .rwd_dx(rwd_dx), .rwd_xm(rwd_xm), .dmwe_xm(dmwe_xm),
        .do_branch(do_branch), .i_busy(i_busy), .d_busy(d_busy),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .wm_bypass(wm_bypass),
        .hold_f(hold_f), .bubble_dx(bubble_dx), .flush_fd(flush_fd),
        .freeze(freeze), .state(state)
`ifdef HAZARD_STATS_EN
        , .load_stall_cnt(load_stall_cnt), .squash_cnt(squash_cnt), .mem_wait_cnt(mem_wait_cnt)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt);
        return {op, 5'(rs), 5'(rt), 16'h0004};
    endfunction

    function automatic logic [31:0] rnd_ins();
        return {OPS[$urandom_range(0, 7)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 11'h020};
    endfunction

    // Register a stage writes, 0 meaning "nothing a consumer can observe".
    function automatic int written_reg(input logic [31:0] ir, input logic rdst, input logic rwe);
        if (!rwe) return 0;
        return rdst ? int'(ir[15:11]) : int'(ir[20:16]);
    endfunction

    function automatic int fwd_model(input int src);
        int from_xm, from_mw;
        from_xm = rwd_xm ? 0 : written_reg(ir_xm, rdst_xm, rwe_xm);
        from_mw = written_reg(ir_mw, rdst_mw, rwe_mw);
        if (src != 0 && src == from_xm) return 1;
        if (src != 0 && src == from_mw) return 2;
        return 0;
    endfunction

    function automatic bit load_use_model();
        int ld, op, rs, rt;
        bit reads_rs, reads_rt;
        ld = written_reg(ir_dx, rdst_dx, rwe_dx);
        if (!rwd_dx || ld == 0) return 1'b0;
        op = int'(ir_fd[31:26]);
        rs = int'(ir_fd[25:21]);
        rt = int'(ir_fd[20:16]);
        reads_rs = !(op == 2 || op == 3);
        reads_rt = (op == 0 || op == 4 || op == 5);
        return (reads_rs && rs == ld) || (reads_rt && rt == ld);
    endfunction

    // Model: squash cycles owed, a memory wait in progress, a one-cycle stall in progress.
    initial begin : compare
        int owed, n_owed, mode, wm_exp, st_exp;
        bit waiting, stalled, n_waiting, n_stalled, busy;
        int e_hold, e_bub, e_flush, e_frz;
        owed = 0; waiting = 0; stalled = 0;
        do @(posedge clock); while (reset !== 1'b1);
        forever begin
            @(negedge clock);
            busy = i_busy || d_busy;
            mode = stalled ? 1 : waiting ? 3 : (owed > 0) ? 2 : 0;
            e_hold = 0; e_bub = 0; e_flush = 0; e_frz = 0;
            n_owed = owed; n_waiting = waiting; n_stalled = 0;
            if (reset) begin
                n_owed = 0; n_waiting = 0;
            end else if (stalled) begin
                // stall lasts exactly one cycle with no controls
            end else if (waiting) begin
                if (busy) e_frz = 1; else n_waiting = 0;
            end else if (busy) begin
                e_frz = 1; n_waiting = 1;
            end else if (owed > 0) begin
                e_flush = 1; e_bub = 1; n_owed = owed - 1;
            end else if (do_branch) begin
                e_flush = 1; e_bub = 1; n_owed = SQ - 1;
            end else if (load_use_model()) begin
                e_hold = 1; e_bub = 1; n_stalled = 1;
            end
            wm_exp = (dmwe_xm && written_reg(ir_mw, rdst_mw, rwe_mw) != 0 &&
                      written_reg(ir_mw, rdst_mw, rwe_mw) == int'(ir_xm[20:16])) ? 1 : 0;
            st_exp = mode;
            chk("state", int'(state), st_exp);
            chk("fwd_a_sel", int'(fwd_a_sel), fwd_model(int'(ir_dx[25:21])));
            chk("fwd_b_sel", int'(fwd_b_sel), fwd_model(int'(ir_dx[20:16])));
            chk("wm_bypass", int'(wm_bypass), wm_exp);
            chk("hold_f", int'(hold_f), e_hold);
            chk("bubble_dx", int'(bubble_dx), e_bub);
            chk("flush_fd", int'(flush_fd), e_flush);
            chk("freeze", int'(freeze), e_frz);
            @(posedge clock);
            owed = n_owed; waiting = n_waiting; stalled = n_stalled;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear();
        ir_fd = {NOP, 26'd0}; ir_dx = {NOP, 26'd0}; ir_xm = {NOP, 26'd0}; ir_mw = {NOP, 26'd0};
        rwe_dx = 0; rwe_xm = 0; rwe_mw = 0; rdst_dx = 0; rdst_xm = 0; rdst_mw = 0;
        rwd_dx = 0; rwd_xm = 0; dmwe_xm = 0; do_branch = 0; i_busy = 0; d_busy = 0;
    endtask

    task automatic set_load_use();
        ir_dx = i_ins(6'h23, 1, 3); rwe_dx = 1; rdst_dx = 0; rwd_dx = 1;
        ir_fd = r_ins(3, 2, 4);
    endtask

    initial begin
        clear();
        reset = 1;
        tick(); tick();
        reset = 0;
        @(negedge clock);
        chk("reset_state", int'(state), 0);
        chk("reset_hold", int'(hold_f), 0);

        // add r3 then sub using r3: MX, then WX a cycle later
        tick(); clear();
        ir_xm = r_ins(1, 2, 3); rwe_xm = 1; rdst_xm = 1; ir_dx = r_ins(3, 5, 4);
        @(negedge clock);
        chk("t1_mx_a", int'(fwd_a_sel), 1);
        chk("t1_mx_b", int'(fwd_b_sel), 0);
        tick(); clear();
        ir_mw = r_ins(1, 2, 3); rwe_mw = 1; rdst_mw = 1;
        ir_xm = r_ins(1, 2, 8); rwe_xm = 1; rdst_xm = 1; ir_dx = r_ins(3, 7, 6);
        @(negedge clock);
        chk("t1_wx_a", int'(fwd_a_sel), 2);

        // lw r3 then add using r3: one stall cycle, then WX
        tick(); clear(); set_load_use();
        @(negedge clock);
        chk("t2_hold", int'(hold_f), 1);
        chk("t2_bubble", int'(bubble_dx), 1);
        tick(); clear();
        ir_fd = r_ins(3, 2, 4); ir_xm = i_ins(6'h23, 1, 3); rwe_xm = 1; rwd_xm = 1;
        @(negedge clock);
        chk("t2_stall_state", int'(state), 1);
        chk("t2_stall_hold", int'(hold_f), 0);
        tick(); clear();
        ir_dx = r_ins(3, 2, 4); ir_mw = i_ins(6'h23, 1, 3); rwe_mw = 1;
        @(negedge clock);
        chk("t2_state_run", int'(state), 0);
        chk("t2_wx_a", int'(fwd_a_sel), 2);

        // lw r3 then sw r3: no stall, WM bypass later
        tick(); clear();
        ir_dx = i_ins(6'h23, 1, 3); rwe_dx = 1; rwd_dx = 1; ir_fd = i_ins(6'h2B, 2, 3);
        @(negedge clock);
        chk("t3_no_hold", int'(hold_f), 0);
        tick(); clear();
        ir_xm = i_ins(6'h2B, 2, 3); dmwe_xm = 1; ir_mw = i_ins(6'h23, 1, 3); rwe_mw = 1;
        @(negedge clock);
        chk("t3_wm", int'(wm_bypass), 1);

        // taken branch with a simultaneous load-use hazard
        tick(); clear(); set_load_use(); do_branch = 1;
        @(negedge clock);
        chk("t4_flush0", int'(flush_fd), 1);
        chk("t4_hold0", int'(hold_f), 0);
        tick(); clear();
        @(negedge clock);
        chk("t4_sq_state", int'(state), 2);
        chk("t4_flush1", int'(flush_fd), 1);
        tick();
        @(negedge clock);
        chk("t4_run", int'(state), 0);
        chk("t4_flush2", int'(flush_fd), 0);

        // d_busy for 3 cycles arriving mid-squash
        tick(); clear(); do_branch = 1;
        tick(); clear(); d_busy = 1;
        @(negedge clock);
        chk("t5_frz0", int'(freeze), 1);
        chk("t5_flush0", int'(flush_fd), 0);
        tick();
        tick();
        @(negedge clock);
        chk("t5_wait_state", int'(state), 3);
        chk("t5_frz2", int'(freeze), 1);
        tick(); d_busy = 0;
        @(negedge clock);
        chk("t5_frz_off", int'(freeze), 0);
        tick();
        @(negedge clock);
        chk("t5_resume_sq", int'(state), 2);
        chk("t5_resume_flush", int'(flush_fd), 1);
        tick();
        @(negedge clock);
        chk("t5_run", int'(state), 0);

        // r0 never forwards or stalls
        tick(); clear();
        ir_xm = r_ins(1, 2, 0); rwe_xm = 1; rdst_xm = 1;
        ir_mw = r_ins(1, 2, 0); rwe_mw = 1; rdst_mw = 1; ir_dx = r_ins(0, 0, 4);
        @(negedge clock);
        chk("t6_r0_a", int'(fwd_a_sel), 0);
        chk("t6_r0_b", int'(fwd_b_sel), 0);
        tick(); clear();
        ir_dx = i_ins(6'h23, 1, 0); rwe_dx = 1; rwd_dx = 1; ir_fd = r_ins(0, 0, 4);
        @(negedge clock);
        chk("t6_r0_hold", int'(hold_f), 0);

        // reset during LOAD_STALL
        tick(); clear(); set_load_use();
        tick(); clear(); set_load_use(); reset = 1;
        @(negedge clock);
        chk("t6_rst_hold", int'(hold_f), 0);
        tick(); clear(); reset = 0;
        @(negedge clock);
        chk("t6_rst_state", int'(state), 0);
        chk("t6_rst_bubble", int'(bubble_dx), 0);

        // randomized traffic, checked by the compare process every cycle
        for (int n = 0; n < 3000; n++) begin
            tick();
            ir_fd = rnd_ins(); ir_dx = rnd_ins(); ir_xm = rnd_ins(); ir_mw = rnd_ins();
            rwe_dx = ($urandom_range(0, 3) != 0); rwe_xm = ($urandom_range(0, 3) != 0);
            rwe_mw = ($urandom_range(0, 3) != 0);
            rdst_dx = 1'($urandom_range(0, 1)); rdst_xm = 1'($urandom_range(0, 1));
            rdst_mw = 1'($urandom_range(0, 1));
            rwd_dx = ($urandom_range(0, 2) == 0); rwd_xm = ($urandom_range(0, 2) == 0);
            dmwe_xm = ($urandom_range(0, 2) == 0);
            do_branch = ($urandom_range(0, 7) == 0);
            i_busy = ($urandom_range(0, 11) == 0); d_busy = ($urandom_range(0, 11) == 0);
            reset = ($urandom_range(0, 63) == 0);
        end
        tick(); clear(); reset = 0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
